// File: rtl/memory_pkg.sv
// Shared types and helpers for the memory_2p simple-dual-port memory.
package memory_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int MAX_LATENCY = 3;
    localparam int MERGE_W     = 256;

    // Lane-wise merge: bits of lanes whose enable is set come from new_w, the rest from old_w.
    function automatic logic [MERGE_W-1:0] merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_W-1:0] be,
        input int                 byte_w
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_W; i++) begin
            if (be[i / byte_w]) begin
                res[i] = new_w[i];
            end else begin
                res[i] = old_w[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/memory_2p_chk.sv
// Elaboration-time legality checks for memory_2p parameters.
module memory_2p_chk
    import memory_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int BYTE_W  = 8,
    parameter int LATENCY = 1
) ();

    if ((LATENCY < 1) || (LATENCY > MAX_LATENCY)) begin : g_bad_latency
        $error("memory_2p: LATENCY must be in 1..3");
    end

    if ((WIDTH % BYTE_W) != 0) begin : g_bad_width
        $error("memory_2p: WIDTH must be a multiple of BYTE_W");
    end

endmodule

// File: rtl/memory_2p_rdpipe.sv
// Read pipeline: carries {valid, data} through LATENCY stages; output data holds between valid pulses.
module memory_2p_rdpipe #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]   tail_s;
    logic [WIDTH-1:0]   out_q, out_d;

    // Valid shift chain and final data stage next-state.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_valid;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        if (vld_d[LATENCY-1]) begin
            out_d = tail_s;
        end else begin
            out_d = out_q;
        end
    end

    if (LATENCY > 1) begin : g_mid
        logic [WIDTH-1:0] mid_q [LATENCY-1];
        logic [WIDTH-1:0] mid_d [LATENCY-1];

        // Intermediate data stages shift freely; only the final stage is qualified.
        always_comb begin
            mid_d[0] = in_data;
            for (int i = 1; i < LATENCY - 1; i++) begin
                mid_d[i] = mid_q[i-1];
            end
        end

        // Intermediate data registers carry no reset.
        always_ff @(posedge clk) begin
            mid_q <= mid_d;
        end

        assign tail_s = mid_q[LATENCY-2];
    end else begin : g_direct
        assign tail_s = in_data;
    end

    // Valid bits and the output data stage reset to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            out_q <= '0;
        end else begin
            vld_q <= vld_d;
            out_q <= out_d;
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = out_q;

endmodule

// File: rtl/memory_2p.sv
// Simple-dual-port word memory with byte enables, read pipeline and post-reset clear.
// Define MEMORY_2P_BYPASS_EN for write-first same-address behaviour (read-first otherwise).
module memory_2p
    import memory_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int SIZE    = 64,
    parameter  int BYTE_W  = 8,
    parameter  int LATENCY = 1,
    localparam int LOGSIZE = $clog2(SIZE),
    localparam int NBE     = WIDTH / BYTE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [LOGSIZE-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [NBE-1:0]     wr_be,
    input  logic               rd_en,
    input  logic [LOGSIZE-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid,
    output logic               busy
);

    localparam logic [LOGSIZE:0]   SIZE_L    = (LOGSIZE + 1)'(SIZE);
    localparam logic [LOGSIZE-1:0] LAST_ADDR = LOGSIZE'(SIZE - 1);

    state_t             state_q, state_d;
    logic [LOGSIZE-1:0] clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]   mem_q [SIZE];

    logic               mem_we_s;
    logic [LOGSIZE-1:0] mem_waddr_s;
    logic [WIDTH-1:0]   mem_wdata_s;
    logic [NBE-1:0]     mem_wbe_s;
    logic               pipe_vld_s;
    logic [WIDTH-1:0]   pipe_dat_s;
    logic [WIDTH-1:0]   rd_word_s;
    logic               wr_ok_s, rd_ok_s;

    assign wr_ok_s = ({1'b0, wr_addr} < SIZE_L);
    assign rd_ok_s = ({1'b0, rd_addr} < SIZE_L);

`ifdef MEMORY_2P_BYPASS_EN
    logic [MERGE_W-1:0] fwd_s;

    // Write-first forwarding: same-address read sees the lane-merged write data.
    always_comb begin
        fwd_s = merge(MERGE_W'(mem_q[rd_addr]), MERGE_W'(wr_data), MERGE_W'(wr_be), BYTE_W);
        if (wr_en && wr_ok_s && (wr_addr == rd_addr)) begin
            rd_word_s = fwd_s[WIDTH-1:0];
        end else begin
            rd_word_s = mem_q[rd_addr];
        end
    end
`else
    assign rd_word_s = mem_q[rd_addr];
`endif

    // Clear/ready sequencing, write-port steering and read-request launch.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = wr_data;
        mem_wbe_s   = wr_be;
        pipe_vld_s  = 1'b0;
        pipe_dat_s  = '0;
        case (state_q)
            CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_cnt_q;
                mem_wdata_s = '0;
                mem_wbe_s   = '1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + LOGSIZE'(1);
                end
            end
            READY: begin
                mem_we_s   = wr_en && wr_ok_s;
                pipe_vld_s = rd_en;
                if (rd_en && rd_ok_s) begin
                    pipe_dat_s = rd_word_s;
                end else begin
                    pipe_dat_s = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage array: byte-lane writes, contents established by the clear sequence.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < NBE; i++) begin
                if (mem_wbe_s[i]) begin
                    mem_q[mem_waddr_s][i*BYTE_W +: BYTE_W] <= mem_wdata_s[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign busy = (state_q == CLEAR);

    memory_2p_rdpipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_rdpipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (pipe_vld_s),
        .in_data   (pipe_dat_s),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

    memory_2p_chk #(
        .WIDTH   (WIDTH),
        .BYTE_W  (BYTE_W),
        .LATENCY (LATENCY)
    ) u_chk ();

endmodule

// File: tb/tb_memory_2p.sv
// Directed bench: instance 0 is SIZE=64/LATENCY=1, instance 1 is SIZE=48/LATENCY=3.
module tb_memory_2p;

    logic        clk;
    logic        reset    [2];
    logic        wr_en    [2];
    logic [5:0]  wr_addr  [2];
    logic [15:0] wr_data  [2];
    logic [1:0]  wr_be    [2];
    logic        rd_en    [2];
    logic [5:0]  rd_addr  [2];
    logic [15:0] rd_data  [2];
    logic        rd_valid [2];
    logic        busy     [2];

    int n_cmp = 0;
    int n_err = 0;
    int bc [2];
    int vc [2];

    memory_2p #(.WIDTH(16), .SIZE(64), .BYTE_W(8), .LATENCY(1)) dut0 (
        .clk(clk), .reset(reset[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]), .wr_be(wr_be[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .busy(busy[0])
    );

    memory_2p #(.WIDTH(16), .SIZE(48), .BYTE_W(8), .LATENCY(3)) dut1 (
        .clk(clk), .reset(reset[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]), .wr_be(wr_be[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en[k]   = 1'b1;
        wr_addr[k] = a;
        wr_data[k] = d;
        wr_be[k]   = be;
        tick();
        wr_en[k]   = 1'b0;
    endtask

    task automatic rd_chk(input int k, input logic [5:0] a, input logic [15:0] exp, input string tag);
        int lat;
        lat = (k == 0) ? 1 : 3;
        rd_en[k]   = 1'b1;
        rd_addr[k] = a;
        tick();
        rd_en[k]   = 1'b0;
        for (int i = 1; i < lat; i++) begin
            check({tag, "_early"}, 32'(rd_valid[k]), 32'd0);
            tick();
        end
        check({tag, "_vld"}, 32'(rd_valid[k]), 32'd1);
        check(tag, 32'(rd_data[k]), 32'(exp));
    endtask

    // Counts busy samples and rd_valid pulses over n cycles; drops requests once ready.
    task automatic watch(input int n);
        for (int k = 0; k < 2; k++) begin
            bc[k] = 0;
            vc[k] = 0;
        end
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < 2; k++) begin
                if (busy[k]) begin
                    bc[k]++;
                end else begin
                    wr_en[k] = 1'b0;
                    rd_en[k] = 1'b0;
                end
                if (rd_valid[k]) vc[k]++;
            end
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k]   = 1'b1;
            wr_en[k]   = 1'b0;
            wr_addr[k] = 6'd0;
            wr_data[k] = 16'h0000;
            wr_be[k]   = 2'b00;
            rd_en[k]   = 1'b0;
            rd_addr[k] = 6'd0;
        end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd1);
            check($sformatf("rst_vld%0d", k), 32'(rd_valid[k]), 32'd0);
            check($sformatf("rst_data%0d", k), 32'(rd_data[k]), 32'd0);
        end

        // Requests held during clear must be ignored.
        wr_en[0]   = 1'b1;
        wr_addr[0] = 6'd3;
        wr_data[0] = 16'hFFFF;
        wr_be[0]   = 2'b11;
        rd_en[0]   = 1'b1;
        rd_addr[0] = 6'd3;
        reset[0]   = 1'b0;
        reset[1]   = 1'b0;
        watch(70);
        check("busy_cycles0", 32'(bc[0]), 32'd64);
        check("busy_cycles1", 32'(bc[1]), 32'd48);
        check("clear_vld0", 32'(vc[0]), 32'd0);
        check("clear_vld1", 32'(vc[1]), 32'd0);

        for (int a = 0; a < 64; a++) begin
            rd_en[0]   = 1'b1;
            rd_addr[0] = 6'(a);
            tick();
            check($sformatf("sweep0_vld_%0d", a), 32'(rd_valid[0]), 32'd1);
            check($sformatf("sweep0_data_%0d", a), 32'(rd_data[0]), 32'd0);
        end
        rd_en[0] = 1'b0;
        tick();
        check("sweep0_end_vld", 32'(rd_valid[0]), 32'd0);

        wr(0, 6'd5, 16'hABCD, 2'b11);
        wr(0, 6'd5, 16'h1234, 2'b01);
        rd_chk(0, 6'd5, 16'hAB34, "be_low");
        wr(0, 6'd5, 16'hFFFF, 2'b00);
        rd_chk(0, 6'd5, 16'hAB34, "be_none");
        wr(0, 6'd5, 16'h9900, 2'b10);
        rd_chk(0, 6'd5, 16'h9934, "be_high");

        wr(0, 6'd7, 16'h1111, 2'b11);
        wr_en[0]   = 1'b1;
        wr_addr[0] = 6'd7;
        wr_data[0] = 16'h00FF;
        wr_be[0]   = 2'b11;
        rd_en[0]   = 1'b1;
        rd_addr[0] = 6'd7;
        tick();
        wr_en[0] = 1'b0;
        rd_en[0] = 1'b0;
        check("same_vld", 32'(rd_valid[0]), 32'd1);
`ifdef MEMORY_2P_BYPASS_EN
        check("same_data", 32'(rd_data[0]), 32'h00FF);
`else
        check("same_data", 32'(rd_data[0]), 32'h1111);
`endif
        rd_chk(0, 6'd7, 16'h00FF, "after_same");
        tick();
        check("hold_vld", 32'(rd_valid[0]), 32'd0);
        check("hold_data", 32'(rd_data[0]), 32'h00FF);

        // Latency-3 back-to-back burst.
        for (int a = 0; a < 4; a++) wr(1, 6'(a), 16'(a + 1), 2'b11);
        for (int c = 1; c <= 7; c++) begin
            rd_en[1]   = (c <= 4);
            rd_addr[1] = 6'(c - 1);
            tick();
            check($sformatf("burst_vld_%0d", c), 32'(rd_valid[1]), 32'((c >= 3) && (c <= 6)));
            if ((c >= 3) && (c <= 6)) begin
                check($sformatf("burst_data_%0d", c), 32'(rd_data[1]), 32'(c - 2));
            end
        end
        check("burst_hold", 32'(rd_data[1]), 32'd4);

        wr(1, 6'd50, 16'hFFFF, 2'b11);
        rd_chk(1, 6'd50, 16'h0000, "oor_rd");
        for (int c = 0; c <= 50; c++) begin
            rd_en[1]   = (c < 48);
            rd_addr[1] = 6'(c);
            tick();
            if ((c >= 2) && (c <= 49)) begin
                check($sformatf("sweep1_vld_%0d", c - 2), 32'(rd_valid[1]), 32'd1);
                check($sformatf("sweep1_data_%0d", c - 2), 32'(rd_data[1]),
                      (c - 2 < 4) ? 32'(c - 1) : 32'd0);
            end else begin
                check($sformatf("sweep1_idle_%0d", c), 32'(rd_valid[1]), 32'd0);
            end
        end

        // Reset with two reads in flight.
        rd_en[1]   = 1'b1;
        rd_addr[1] = 6'd0;
        tick();
        rd_addr[1] = 6'd1;
        tick();
        rd_en[1] = 1'b0;
        reset[1] = 1'b1;
        #1;
        check("midrst_vld", 32'(rd_valid[1]), 32'd0);
        check("midrst_busy", 32'(busy[1]), 32'd1);
        tick();
        tick();
        check("midrst_vld2", 32'(rd_valid[1]), 32'd0);
        reset[1] = 1'b0;
        watch(60);
        check("midrst_busy_cycles", 32'(bc[1]), 32'd48);
        check("midrst_pulses", 32'(vc[1]), 32'd0);
        rd_chk(1, 6'd0, 16'h0000, "post_reset_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
